// File: rtl/seg_mux_sched.sv
// seg_mux_sched: round-robin seven-segment digit scanner with blanking gaps and frame-aligned loads
// Ports: clk, reset_n (async active-low); en scan enable; load_data/load_valid/load_ready
// load handshake (nibble i at [4i+3:4i]); nibble_out/digit_sel feed the shared decoder;
// anode_n active-low anode drive; frame_done pulses once per completed frame.
module seg_mux_sched #(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 32,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic                          load_valid,
  output logic                          load_ready,
  output logic [3:0]                    nibble_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic                          frame_done
);
  localparam int MX = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [SW-1:0] SEL_LAST = SW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  // Each digit starts with a blank phase unless blanking is disabled.
  localparam state_t FIRST = BLANK_CYCLES == 0 ? SHOW : BLANK;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0] nib_q, nib_d;
  logic fd_q, fd_d;
  logic [4*NUM_DIGITS-1:0] act_q, act_d, pend_q, pend_d;
  logic pflag_q, pflag_d;
  logic take, dwell_end, frame_end, copy;
  always_comb begin
    take = load_valid && !pflag_q;
    dwell_end = state_q == SHOW && cnt_q == DW_LAST;
    frame_end = dwell_end && sel_q == SEL_LAST;
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sel_d = '0;
        state_d = en ? FIRST : IDLE;
      end
      BLANK: if (cnt_q == BL_LAST) begin
        state_d = SHOW;
        cnt_d = '0;
      end
      SHOW: if (dwell_end) begin
        cnt_d = '0;
        sel_d = (frame_end || !en) ? '0 : sel_q + 1'b1;
        state_d = en ? FIRST : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pending values are promoted only between frames (or while idle) so a frame never tears.
    copy = pflag_q && (state_q == IDLE || frame_end);
    act_d = copy ? pend_q : act_q;
    pend_d = take ? load_data : pend_q;
    pflag_d = take || (pflag_q && !copy);
    fd_d = frame_end;
    // Outputs are derived from the next state so the registered outputs track the FSM state.
    an_d = '1;
    if (state_d == SHOW) an_d[sel_d] = 1'b0;
    nib_d = state_d == IDLE ? 4'h0 : act_d[{sel_d, 2'b00} +: 4];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      an_q    <= '1;
      nib_q   <= '0;
      fd_q    <= 1'b0;
      act_q   <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      nib_q   <= nib_d;
      fd_q    <= fd_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
    end
  end
  assign load_ready = ~pflag_q;
  assign nibble_out = nib_q;
  assign digit_sel  = sel_q;
  assign anode_n    = an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_mux_sched.sv
// tb_seg_mux_sched: checks two scanner configurations against a timeline-based reference model
module tb_seg_mux_sched;
  logic clk = 0, reset_n = 1, en = 0, lv = 0;
  logic [15:0] ld = '0;
  logic rdy0, rdy1, fd0, fd1;
  logic [3:0] nib0, nib1;
  logic [0:0] sel0;
  logic [1:0] sel1;
  logic [1:0] an0;
  logic [3:0] an1;
  int vectors = 0, miscompares = 0;
  int nd[2] = '{2, 4};
  int dw[2] = '{32, 1};
  int bk[2] = '{4, 0};
  bit run[2], pf[2], fd[2];
  int t[2];
  logic [15:0] act[2], pnd[2];
  bit acc;

  seg_mux_sched #(.NUM_DIGITS(2), .DWELL_CYCLES(32), .BLANK_CYCLES(4)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en), .load_data(ld[7:0]), .load_valid(lv),
    .load_ready(rdy0), .nibble_out(nib0), .digit_sel(sel0), .anode_n(an0), .frame_done(fd0));
  seg_mux_sched #(.NUM_DIGITS(4), .DWELL_CYCLES(1), .BLANK_CYCLES(0)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en), .load_data(ld), .load_valid(lv),
    .load_ready(rdy1), .nibble_out(nib1), .digit_sel(sel1), .anode_n(an1), .frame_done(fd1));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run[k] = 0; pf[k] = 0; fd[k] = 0; t[k] = 0; act[k] = '0; pnd[k] = '0;
    end
  endtask

  // t is the cycle offset into the frame; digit = t / period, blanking while offset < BLANK.
  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int p;
      bit take, cp, last;
      p = bk[k] + dw[k];
      take = lv && !pf[k];
      cp = 0;
      fd[k] = 0;
      if (!run[k]) begin
        cp = pf[k];
        if (en) begin run[k] = 1; t[k] = 0; end
      end else if (t[k] % p == p - 1) begin
        last = (t[k] / p == nd[k] - 1);
        if (last) begin fd[k] = 1; cp = pf[k]; end
        if (!en) begin run[k] = 0; t[k] = 0; end
        else t[k] = last ? 0 : t[k] + 1;
      end else t[k]++;
      if (cp) begin act[k] = pnd[k]; pf[k] = 0; end
      if (take) begin pnd[k] = k == 0 ? {8'h00, ld[7:0]} : ld; pf[k] = 1; end
    end
  endtask

  task automatic cmp(string tag, int k, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[u%0d] @%0t: got %h, expected %h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic check();
    for (int k = 0; k < 2; k++) begin
      int p, d;
      logic [3:0] e_an, e_nib;
      p = bk[k] + dw[k];
      d = run[k] ? t[k] / p : 0;
      e_an = 4'hF;
      if (run[k] && t[k] % p >= bk[k]) e_an[d] = 1'b0;
      e_nib = run[k] ? act[k][4*d +: 4] : 4'h0;
      if (k == 0) e_an[3:2] = 2'b11;
      cmp("anode_n", k, k == 0 ? {14'h3FFF, an0} : {12'hFFF, an1}, {12'hFFF, e_an});
      cmp("nibble_out", k, k == 0 ? 16'(nib0) : 16'(nib1), 16'(e_nib));
      cmp("digit_sel", k, k == 0 ? 16'(sel0) : 16'(sel1), 16'(d));
      cmp("frame_done", k, k == 0 ? 16'(fd0) : 16'(fd1), 16'(fd[k]));
      cmp("load_ready", k, k == 0 ? 16'(rdy0) : 16'(rdy1), 16'(!pf[k]));
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check();
    end
  endtask

  function automatic bit cond(int w);
    return w == 0 ? (run[0] && t[0] >= 4 && t[0] < 36) :
           w == 1 ? bit'(rdy0) : (run[0] && t[0] % 36 >= 4);
  endfunction

  task automatic wait_until(int what, int lim);
    bit hit;
    hit = 0;
    for (int i = 0; i < lim && !hit; i++) begin
      hit = cond(what);
      if (!hit) step(1);
    end
    vectors++;
    assert (hit) else begin
      miscompares++;
      $error("FAIL wait%0d: got timeout, expected event within %0d cycles", what, lim);
    end
  endtask

  initial begin
    #1 reset_n = 0;
    #1 model_reset();
    check();
    @(negedge clk);
    reset_n = 1; ld = 16'h935A; lv = 1; en = 0;
    step(1);
    lv = 0;
    step(3);
    en = 1;
    step(20);
    lv = 1; ld = 16'hC437;
    step(1);
    ld = 16'h0B6E;
    wait_until(1, 400);
    step(1);
    lv = 0;
    step(200);
    wait_until(0, 200);
    en = 0;
    step(80);
    en = 1;
    step(100);
    wait_until(2, 200);
    #2 reset_n = 0;
    #1 model_reset();
    check();
    @(negedge clk);
    reset_n = 1;
    step(100);
    repeat (2500) begin
      en = $urandom_range(0, 40) != 0;
      if (!lv) begin
        lv = $urandom_range(0, 9) == 0;
        ld = 16'($urandom);
      end
      acc = lv && rdy0;
      step(1);
      if (acc) lv = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg_mux_sched.md
Name: seg_mux_sched

Overview:
- Time-multiplexing scheduler for a bank of common-anode seven-segment digits that share one seven_seg_disp decoder.
- Cycles through the digits round-robin. Each digit gets a programmable dwell time, preceded by a blanking gap that prevents ghosting.
- Accepts new digit values through a valid/ready handshake. New values take effect only at frame boundaries, so the display never tears.
- Sits between the switch/sum logic and the shared decoder plus anode drivers.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits (2..8).
- DWELL_CYCLES, 32, clk cycles each digit is driven (>=1).
- BLANK_CYCLES, 4, clk cycles all anodes are off before each digit (>=0; 0 disables blanking).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; 0 halts the scan at the next digit boundary with all anodes off.
- load_data  input  4*NUM_DIGITS  new digit nibbles; digit i is at bits [4i+3:4i].
- load_valid  input  1  load_data is valid.
- load_ready  output  1  scheduler can accept a load.
- nibble_out  output  4  nibble for the shared decoder.
- digit_sel  output  $clog2(NUM_DIGITS)  index of the current digit.
- anode_n  output  NUM_DIGITS  active-low anode drive, one-hot-low or all-high.
- frame_done  output  1  one-cycle pulse after the last digit's dwell completes.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, digit_sel=0, anode_n=all 1s, nibble_out=0, frame_done=0, load_ready=1.
  - Active and pending buffers cleared to 0; pending flag cleared.
- Registers:
  - active buffer (displayed values).
  - pending buffer plus pending flag.
  - cnt, width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
- Load handshake:
  - Transfer occurs on a clk edge with load_valid && load_ready. load_data goes to the pending buffer and the pending flag is set.
  - load_ready = ~pending flag (registered). Exactly one load is buffered; load_valid while ready=0 is ignored and the requester must hold.
  - Pending is copied to active, and the flag cleared, at the frame boundary (see SHOW). The copy also happens in IDLE on the cycle after capture.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: anode_n all 1s, digit_sel=0. When en=1, go to BLANK with cnt=0. If BLANK_CYCLES=0, go directly to SHOW.
  - BLANK:
    - anode_n all 1s; nibble_out=active[digit_sel] (pre-settles the decoder).
    - cnt increments. When cnt==BLANK_CYCLES-1, go to SHOW with cnt=0.
  - SHOW:
    - anode_n[digit_sel]=0, all others 1.
    - nibble_out=active[digit_sel]; cnt increments.
    - When cnt==DWELL_CYCLES-1 and digit_sel!=NUM_DIGITS-1: digit_sel+1, then BLANK (or SHOW if BLANK_CYCLES=0).
    - When cnt==DWELL_CYCLES-1 and digit_sel==NUM_DIGITS-1 (frame boundary):
      - frame_done pulses high for the next cycle only.
      - digit_sel wraps to 0.
      - Pending copy happens if the flag is set.
      - Next state is BLANK/SHOW if en=1, else IDLE.
- en deasserted mid-digit: the current dwell finishes. At that digit boundary go to IDLE with digit_sel=0 and all anodes off. frame_done pulses only if it is the last digit.
- Load captured in the same cycle as a frame boundary: the capture goes to pending and is applied at the next boundary. The copy uses the pre-edge pending contents.
- Timing:
  - Digit period = BLANK_CYCLES+DWELL_CYCLES.
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES).
  - anode_n is never low for two digits in the same cycle.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset mid-operation: all outputs return to reset values immediately. A pending load is discarded.

Test Plan:
- Reset with en=1, defaults (N=2, DWELL=32, BLANK=4), load 8'h5A before scan starts:
  - anode_n=11 for 4 cycles, then 10 for 32 cycles with nibble_out=A.
  - Then 11 for 4 cycles, then 01 for 32 cycles with nibble_out=5.
  - frame_done pulses once every 72 cycles.
- Load 8'h37 mid-frame while digit 0 is showing A:
  - load_ready drops to 0.
  - Digit 1 still shows 5.
  - After frame_done, digit 0 shows 7 and digit 1 shows 3; load_ready returns to 1.
- Second load_valid held while load_ready=0:
  - Not accepted until after the boundary.
  - Accepted data appears one frame later; no value is lost or duplicated.
- Drop en during digit 0's dwell:
  - Digit 0 completes 32 cycles, then IDLE with anode_n=11 and no frame_done.
  - Reassert en: scan restarts at digit 0 with a blank phase.
- Assert reset_n=0 asynchronously mid-SHOW:
  - anode_n=11, nibble_out=0, load_ready=1 immediately, without waiting for a clk edge.
  - After release, the active buffer is 0.
- BLANK_CYCLES=0, DWELL_CYCLES=1, N=4:
  - anode_n walks 1110, 1101, 1011, 0111 on consecutive cycles.
  - frame_done pulses every 4 cycles; never two anodes low at once.
